mc_control_fsm: RTL and testbench

- Multicycle main control unit for the RISC-V core. It is the command side of the ALU interface: it generates the 3-bit ALU control code and the datapath strobes each cycle.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU and beq.
- Handshakes with instruction/data memory via mem_req/mem_ready.
- Sits between the instruction register and the datapath muxes, register file and ALU.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 39 +++
 rtl/mc_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU codes, opcodes, mux selects and control states
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // How the ALU decoder should interpret funct3/funct7_5 this cycle.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    function automatic logic funct3_supported(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b111) ||
               (funct3 == 3'b110) || (funct3 == 3'b010);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op/funct3/funct7_5 to the 3-bit ALU control code
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    logic [2:0] func_ctrl;
    logic       sub_sel;

    // valid depends on funct3 alone so DECODE can qualify R/I-type before EXEC.
    assign valid   = funct3_supported(funct3);
    assign sub_sel = funct7_5 && (alu_op == ALU_OP_RTYPE);

    always_comb begin
        func_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  func_ctrl = sub_sel ? ALU_SUB : ALU_ADD;
            3'b111:  func_ctrl = ALU_AND;
            3'b110:  func_ctrl = ALU_OR;
            3'b010:  func_ctrl = ALU_SLT;
            default: func_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            default:    alu_ctrl = func_ctrl;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle main control FSM driving ALU code and datapath strobes
module mc_control_fsm
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_ctrl,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       dec_valid;
    logic       unused_xlen;

    assign unused_xlen = (XLEN != 0);
    assign state_o     = state;

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (alu_ctrl),
        .valid    (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_ILLEGAL) begin
                illegal <= 1'b1;
            end
        end
    end

    // Kept apart from the next-state block: dec_valid feeds next_state and
    // the decoder reads alu_op, so one block would form a false loop.
    always_comb begin
        alu_op = ALU_OP_ADD;
        if (!rst) begin
            case (state)
                S_EXECR:  alu_op = ALU_OP_RTYPE;
                S_EXECI:  alu_op = ALU_OP_ITYPE;
                S_BRANCH: alu_op = ALU_OP_SUB;
                default:  alu_op = ALU_OP_ADD;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALU;
        adr_src    = ADR_PC;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = dec_valid ? S_EXECR : S_ILLEGAL;
                    OP_I:         next_state = dec_valid ? S_EXECI : S_ILLEGAL;
                    OP_BEQ:       next_state = S_BRANCH;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = opcode[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                next_state = S_FETCH;
            end
            S_ILLEGAL: begin
                next_state = S_ILLEGAL;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // A reset cycle must never commit anything, even mid-access.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm
module tb_mc_control_fsm;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        state_t st;
        logic   mr;
        logic   z;
        logic   r;
    } step_t;

    // alu_ctrl, strobes kept; mux selects are don't-care while in reset
    localparam logic [14:0] RST_MASK = 15'b111_00_00_00_0_11111;

    logic [14:0] outs;
    assign outs = {alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src,
                   mem_req, mem_we, ir_write, pc_write, reg_write};

    always #5 clk = ~clk;

    mc_control_fsm #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return f7 ? 3'b001 : 3'b000;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b010) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic [14:0] exp_out(input state_t st, input logic mr, input logic z,
                                            input logic [2:0] f3, input logic f7);
        logic [2:0] a  = 3'b000;
        logic [1:0] sa = 2'b00;
        logic [1:0] sb = 2'b00;
        logic [1:0] rs = 2'b00;
        logic ad = 1'b0, rq = 1'b0, we = 1'b0, ir = 1'b0, pc = 1'b0, rw = 1'b0;
        case (st)
            S_FETCH:  begin rq = 1'b1; sb = 2'b10; ir = mr; pc = mr; end
            S_DECODE: begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR: begin sa = 2'b10; sb = 2'b01; end
            S_MEMRD:  begin rq = 1'b1; ad = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; rs = 2'b01; end
            S_MEMWR:  begin rq = 1'b1; we = 1'b1; ad = 1'b1; end
            S_EXECR:  begin sa = 2'b10; a = ref_alu(f3, f7); end
            S_EXECI:  begin sa = 2'b10; sb = 2'b01; a = ref_alu(f3, 1'b0); end
            S_ALUWB:  begin rw = 1'b1; rs = 2'b10; end
            S_BRANCH: begin sa = 2'b10; a = 3'b001; rs = 2'b10; pc = z; end
            default:  ;
        endcase
        return {a, sa, sb, rs, ad, rq, we, ir, pc, rw};
    endfunction

    // zsel: 0/1 forces zero in BRANCH, 2 randomizes. abort>=0 resets after that many memory waits.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int wf, input int wm, input int zsel, input int abort);
        step_t  q[$];
        state_t st_mem;
        logic   legal;
        int     ill_n;
        legal = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
        for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0, rbit(), 1'b0});
        q.push_back('{S_FETCH, 1'b1, rbit(), 1'b0});
        q.push_back('{S_DECODE, rbit(), rbit(), 1'b0});
        if (op == 7'b0000011 || op == 7'b0100011) begin
            q.push_back('{S_MEMADR, rbit(), rbit(), 1'b0});
            st_mem = (op == 7'b0100011) ? S_MEMWR : S_MEMRD;
            if (abort >= 0) begin
                for (int i = 0; i < abort; i++) q.push_back('{st_mem, 1'b0, rbit(), 1'b0});
                q.push_back('{st_mem, 1'b1, rbit(), 1'b1});
            end else begin
                for (int i = 0; i < wm; i++) q.push_back('{st_mem, 1'b0, rbit(), 1'b0});
                q.push_back('{st_mem, 1'b1, rbit(), 1'b0});
                if (op == 7'b0000011) q.push_back('{S_MEMWB, rbit(), rbit(), 1'b0});
            end
        end else if ((op == 7'b0110011 || op == 7'b0010011) && legal) begin
            q.push_back('{(op == 7'b0110011) ? S_EXECR : S_EXECI, rbit(), rbit(), 1'b0});
            q.push_back('{S_ALUWB, rbit(), rbit(), 1'b0});
        end else if (op == 7'b1100011) begin
            q.push_back('{S_BRANCH, rbit(), (zsel == 2) ? rbit() : (zsel == 1), 1'b0});
        end else begin
            for (int i = 0; i < 20; i++) q.push_back('{S_ILLEGAL, rbit(), rbit(), 1'b0});
            q.push_back('{S_ILLEGAL, rbit(), rbit(), 1'b1});
        end

        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        ill_n    = 0;
        foreach (q[i]) begin
            rst       = q[i].r;
            mem_ready = q[i].mr;
            zero      = q[i].z;
            @(negedge clk);
            check_eq("state", 32'(state_o), 32'(q[i].st));
            if (q[i].r)
                check_eq("rst_outs", 32'(outs & RST_MASK), 32'd0);
            else
                check_eq("outs", 32'(outs), 32'(exp_out(q[i].st, q[i].mr, q[i].z, f3, f7)));
            if (q[i].st == S_ILLEGAL) begin
                if (ill_n > 0) check_eq("illegal", 32'(illegal), 32'd1);
                ill_n++;
            end else begin
                check_eq("illegal", 32'(illegal), 32'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] op;
        int         kind;
        int         ab;

        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        zero = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_outs", 32'(outs & RST_MASK), 32'd0);
        check_eq("reset_illegal", 32'(illegal), 32'd0);
        check_eq("reset_state", 32'(state_o), 32'(S_FETCH));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 2, -1);
        run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 2, -1);
        run_instr(7'b0110011, 3'b010, 1'b0, 0, 0, 2, -1);
        run_instr(7'b0110011, 3'b111, 1'b0, 1, 0, 2, -1);
        run_instr(7'b0110011, 3'b110, 1'b1, 0, 0, 2, -1);
        run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 2, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 2, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 2, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 0, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 2, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 2, 2);
        run_instr(7'b0110011, 3'b001, 1'b0, 0, 0, 2, -1);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(5));
            case (kind)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1100011;
                default: begin
                    op = 7'($urandom);
                    if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                        op == 7'b0010011 || op == 7'b1100011) op = 7'b1111111;
                end
            endcase
            ab = (kind <= 1 && $urandom_range(3) == 0) ? int'($urandom_range(2)) : -1;
            run_instr(op, 3'($urandom), rbit(), int'($urandom_range(3)),
                      int'($urandom_range(3)), 2, ab);
        end

        rst = 1'b0;
        @(negedge clk);
        check_eq("final_state", 32'(state_o), 32'(S_FETCH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
